// File: rtl/bus_wait_injector.sv
`timescale 1ns/1ps
// Wait-state injector between NUM_CH simple-bus masters and zero-latency slaves.
// Each channel issues one slave access per request, then stalls W extra cycles.
module bus_wait_injector #(
  parameter int          NUM_CH     = 2,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          WAIT_WIDTH = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          CNT_WIDTH  = 16,
  localparam int         BE_W       = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH*WAIT_WIDTH-1:0]     cfg_wait,
  input  logic [NUM_CH-1:0]                cfg_random,
  input  logic [NUM_CH-1:0]                m_read,
  input  logic [NUM_CH-1:0]                m_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]     m_address,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     m_wrdata,
  input  logic [NUM_CH*BE_W-1:0]           m_byteenable,
  output logic [NUM_CH*DATA_WIDTH-1:0]     m_rddata,
  output logic [NUM_CH-1:0]                m_stall,
  output logic [NUM_CH-1:0]                s_read,
  output logic [NUM_CH-1:0]                s_write,
  output logic [NUM_CH*ADDR_WIDTH-1:0]     s_address,
  output logic [NUM_CH*DATA_WIDTH-1:0]     s_wrdata,
  output logic [NUM_CH*BE_W-1:0]           s_byteenable,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     s_rddata,
  output logic [NUM_CH-1:0]                err_premature,
  output logic [NUM_CH*CNT_WIDTH-1:0]      txn_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  // Galois form of x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Window of WAIT_WIDTH bits starting at off, wrapping past bit 15.
  function automatic logic [WAIT_WIDTH-1:0] lfsr_slice(input logic [15:0] v, input int off);
    logic [WAIT_WIDTH-1:0] r;
    logic [3:0]            idx;
    r = '0;
    for (int b = 0; b < WAIT_WIDTH; b++) begin
      idx  = 4'((off + b) % 16);
      r[b] = v[idx];
    end
    return r;
  endfunction

  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next(lfsr);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : ch_g
    localparam int OFF = (i * WAIT_WIDTH) % 16;

    state_t                state;
    logic                  rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_W-1:0]       be_q;
    logic [WAIT_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  s_read_q;
    logic                  s_write_q;
    logic                  err_q;
    logic [CNT_WIDTH-1:0]  txn_q;
    logic [WAIT_WIDTH-1:0] cfg_w;
    logic [WAIT_WIDTH-1:0] w_sel;
    logic                  violation;
    logic                  stall_c;

    assign cfg_w = cfg_wait[i*WAIT_WIDTH +: WAIT_WIDTH];
    assign w_sel = cfg_random[i] ? (lfsr_slice(lfsr, OFF) & cfg_w) : cfg_w;

    // The master must hold the captured strobe and address until it sees completion.
    assign violation = (rd_q ? !m_read[i] : !m_write[i]) ||
                       (m_address[i*ADDR_WIDTH +: ADDR_WIDTH] != addr_q);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= IDLE;
        rd_q      <= 1'b0;
        addr_q    <= '0;
        wdata_q   <= '0;
        be_q      <= '0;
        cnt_q     <= '0;
        rdata_q   <= '0;
        s_read_q  <= 1'b0;
        s_write_q <= 1'b0;
        err_q     <= 1'b0;
        txn_q     <= '0;
      end else begin
        s_read_q  <= 1'b0;
        s_write_q <= 1'b0;
        case (state)
          IDLE: begin
            if (m_read[i] || m_write[i]) begin
              rd_q      <= m_read[i];
              addr_q    <= m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_q   <= m_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
              be_q      <= m_byteenable[i*BE_W +: BE_W];
              cnt_q     <= w_sel;
              s_read_q  <= m_read[i];
              s_write_q <= !m_read[i];
              state     <= ACCESS;
            end
          end
          ACCESS: begin
            if (rd_q) rdata_q <= s_rddata[i*DATA_WIDTH +: DATA_WIDTH];
            if (violation) begin
              err_q <= 1'b1;
              state <= IDLE;
            end else if (cnt_q != '0) begin
              state <= WAIT;
            end else begin
              state <= DONE;
            end
          end
          WAIT: begin
            if (violation) begin
              err_q <= 1'b1;
              state <= IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
              if (cnt_q == WAIT_WIDTH'(1)) state <= DONE;
            end
          end
          DONE: begin
            if (violation) begin
              err_q <= 1'b1;
            end else begin
              txn_q <= txn_q + 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end

    always_comb begin
      stall_c = 1'b0;
      case (state)
        IDLE:        stall_c = m_read[i] | m_write[i];
        ACCESS, WAIT: stall_c = 1'b1;
        default:     stall_c = 1'b0;
      endcase
    end

    assign m_stall[i]                                 = stall_c;
    assign m_rddata[i*DATA_WIDTH +: DATA_WIDTH]       = rdata_q;
    assign s_read[i]                                  = s_read_q;
    assign s_write[i]                                 = s_write_q;
    assign s_address[i*ADDR_WIDTH +: ADDR_WIDTH]      = addr_q;
    assign s_wrdata[i*DATA_WIDTH +: DATA_WIDTH]       = wdata_q;
    assign s_byteenable[i*BE_W +: BE_W]               = be_q;
    assign err_premature[i]                           = err_q;
    assign txn_count[i*CNT_WIDTH +: CNT_WIDTH]        = txn_q;
  end

endmodule

// File: tb/tb_bus_wait_injector.sv
`timescale 1ns/1ps
// Scoreboard bench for bus_wait_injector: drivers queue expected slave accesses
// and completions; a monitor pops and compares them as the DUT produces them.
module tb_bus_wait_injector;
  localparam int          NCH  = 2;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          WW   = 4;
  localparam int          CW   = 16;
  localparam int          BEW  = DW / 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NCH*WW-1:0]   cfg_wait = '0;
  logic [NCH-1:0]      cfg_random = '0;
  logic [NCH-1:0]      m_read = '0;
  logic [NCH-1:0]      m_write = '0;
  logic [NCH*AW-1:0]   m_address = '0;
  logic [NCH*DW-1:0]   m_wrdata = '0;
  logic [NCH*BEW-1:0]  m_byteenable = '0;
  logic [NCH*DW-1:0]   m_rddata;
  logic [NCH-1:0]      m_stall;
  logic [NCH-1:0]      s_read;
  logic [NCH-1:0]      s_write;
  logic [NCH*AW-1:0]   s_address;
  logic [NCH*DW-1:0]   s_wrdata;
  logic [NCH*BEW-1:0]  s_byteenable;
  logic [NCH*DW-1:0]   s_rddata;
  logic [NCH-1:0]      err_premature;
  logic [NCH*CW-1:0]   txn_count;

  always #5 clk = ~clk;

  bus_wait_injector #(
    .NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_WIDTH(WW),
    .LFSR_SEED(SEED), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_wait(cfg_wait), .cfg_random(cfg_random),
    .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_wrdata(m_wrdata), .m_byteenable(m_byteenable), .m_rddata(m_rddata),
    .m_stall(m_stall), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_wrdata(s_wrdata), .s_byteenable(s_byteenable),
    .s_rddata(s_rddata), .err_premature(err_premature), .txn_count(txn_count)
  );

  // Zero-latency slave: read data is a fixed function of the address.
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'h8000_0010) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'hA5C3_3C5A;
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : slv_g
    assign s_rddata[g*DW +: DW] = slave_data(s_address[g*AW +: AW]);
  end

  // Reference random source: the x^16+x^14+x^13+x^11+1 Galois sequence from the seed.
  function automatic logic [15:0] galois(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  logic [15:0] mlfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) mlfsr <= SEED;
    else     mlfsr <= galois(mlfsr);
  end

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          stall;
    logic [31:0] rdata;
    int          cnt;
  } exp_t;

  exp_t        comp_q[NCH][$];
  exp_t        slv_q[NCH][$];
  int          rec_q[NCH][$];
  int          rec_a[NCH][$];
  int          exp_cnt[NCH];
  logic [31:0] last_rd[NCH];
  int          stall_cnt[NCH];
  bit          recording = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d: got %0h, expected %0h", name, ch, act, exp);
    end
  endtask

  function automatic int calc_w(input int ch, input logic [3:0] wcfg, input bit rnd);
    logic [3:0] rv;
    rv = 4'(mlfsr >> ((ch * WW) % 16));
    return rnd ? int'(rv & wcfg) : int'(wcfg);
  endfunction

  // mode < 0: run to completion; mode = 0: issue and return; mode > 0: drop after mode cycles.
  task automatic do_txn(input int ch, input bit rd, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic [3:0] wcfg, input bit rnd, input int mode);
    exp_t e;
    int   k;
    @(posedge clk); #1;
    cfg_wait[ch*WW +: WW]      = wcfg;
    cfg_random[ch]             = rnd;
    m_read[ch]                 = rd;
    m_write[ch]                = !rd;
    m_address[ch*AW +: AW]     = addr;
    m_wrdata[ch*DW +: DW]      = data;
    m_byteenable[ch*BEW +: BEW] = be;
    e.rd    = rd;
    e.addr  = addr;
    e.data  = data;
    e.be    = be;
    e.stall = 2 + calc_w(ch, wcfg, rnd);
    e.cnt   = exp_cnt[ch];
    slv_q[ch].push_back(e);
    if (rd) last_rd[ch] = slave_data(addr);
    e.rdata = last_rd[ch];
    if (mode < 0) begin
      comp_q[ch].push_back(e);
      exp_cnt[ch]++;
      k = 0;
      forever begin
        @(negedge clk);
        if (!m_stall[ch]) break;
        k++;
        if (k > 40) begin
          n_tests++;
          n_fail++;
          $display("FAIL completion_timeout ch%0d: got stall after %0d cycles, expected completion", ch, k);
          break;
        end
      end
    end else if (mode > 0) begin
      repeat (mode) @(posedge clk);
      #1;
      m_read[ch]  = 1'b0;
      m_write[ch] = 1'b0;
    end
  endtask

  task automatic release_ch(input int ch);
    @(posedge clk); #1;
    m_read[ch]  = 1'b0;
    m_write[ch] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst     = 1'b1;
    m_read  = '0;
    m_write = '0;
    for (int c = 0; c < NCH; c++) begin
      comp_q[c].delete();
      slv_q[c].delete();
      exp_cnt[c] = 0;
      last_rd[c] = '0;
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic run_reads(input int ch, input int n);
    for (int t = 0; t < n; t++) do_txn(ch, 1'b1, $urandom, 32'h0, 4'hF, 4'hF, 1'b1, -1);
    release_ch(ch);
  endtask

  task automatic run_mixed(input int ch, input int n);
    for (int t = 0; t < n; t++) begin
      do_txn(ch, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
             4'($urandom), 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 2) == 0) begin
        release_ch(ch);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end
    release_ch(ch);
  endtask

  // Monitor: slave strobes and master completions.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int c = 0; c < NCH; c++) stall_cnt[c] = 0;
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (s_read[c] || s_write[c]) begin
            if (slv_q[c].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL slave_strobe ch%0d: got r=%0b w=%0b, expected no access", c, s_read[c], s_write[c]);
            end else begin
              e = slv_q[c].pop_front();
              check("slave_dir", c, 64'({s_read[c], s_write[c]}), 64'({e.rd, !e.rd}));
              check("slave_addr", c, 64'(s_address[c*AW +: AW]), 64'(e.addr));
              if (!e.rd) begin
                check("slave_wrdata", c, 64'(s_wrdata[c*DW +: DW]), 64'(e.data));
                check("slave_be", c, 64'(s_byteenable[c*BEW +: BEW]), 64'(e.be));
              end
            end
          end
          if (m_read[c] || m_write[c]) begin
            if (m_stall[c]) begin
              stall_cnt[c]++;
            end else begin
              if (comp_q[c].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL completion ch%0d: got unexpected completion, expected none", c);
              end else begin
                e = comp_q[c].pop_front();
                check("stall_len", c, 64'(stall_cnt[c]), 64'(e.stall));
                check("m_rddata", c, 64'(m_rddata[c*DW +: DW]), 64'(e.rdata));
                check("txn_count", c, 64'(txn_count[c*CW +: CW]), 64'(e.cnt));
                if (recording) begin
                  rec_q[c].push_back(stall_cnt[c]);
                  check("stall_range", c, 64'(stall_cnt[c] >= 2 && stall_cnt[c] <= 17), 64'(1));
                end
              end
              stall_cnt[c] = 0;
            end
          end else begin
            stall_cnt[c] = 0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog ch0: got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    for (int c = 0; c < NCH; c++) begin
      exp_cnt[c] = 0;
      last_rd[c] = '0;
      stall_cnt[c] = 0;
    end
    // Reset state, with a request present on ch0 only.
    m_read[0] = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_m_stall", 0, 64'(m_stall), 64'(2'b01));
    check("rst_s_strobes", 0, 64'({s_read, s_write}), 64'(0));
    check("rst_s_address", 0, 64'(s_address), 64'(0));
    check("rst_s_wrdata_be", 0, 64'({s_wrdata[31:0], s_byteenable}), 64'(0));
    check("rst_m_rddata", 0, 64'(m_rddata), 64'(0));
    check("rst_err", 0, 64'(err_premature), 64'(0));
    check("rst_txn_count", 0, 64'(txn_count), 64'(0));
    m_read[0] = 1'b0;
    #1 rst = 1'b0;

    // Fixed-wait read, then a zero-wait write on ch1.
    do_txn(0, 1'b1, 32'h8000_0010, 32'h0, 4'hF, 4'd4, 1'b0, -1);
    release_ch(0);
    do_txn(1, 1'b0, 32'h0000_2000, 32'h1234_5678, 4'b0011, 4'd0, 1'b0, -1);
    release_ch(1);
    @(negedge clk);
    check("count_after_read", 0, 64'(txn_count[CW-1:0]), 64'(1));
    check("count_after_write", 1, 64'(txn_count[2*CW-1:CW]), 64'(1));

    // Read dropped in the second WAIT cycle.
    do_txn(0, 1'b1, 32'h8000_0020, 32'h0, 4'hF, 4'd4, 1'b0, 3);
    @(posedge clk);
    @(negedge clk);
    check("drop_err", 0, 64'(err_premature[0]), 64'(1));
    check("drop_idle_stall", 0, 64'(m_stall[0]), 64'(0));
    check("drop_count", 0, 64'(txn_count[CW-1:0]), 64'(exp_cnt[0]));
    do_txn(0, 1'b1, 32'h8000_0010, 32'h0, 4'hF, 4'd4, 1'b0, -1);
    release_ch(0);
    @(negedge clk);
    check("err_sticky", 0, 64'(err_premature[0]), 64'(1));

    // Simultaneous read/write, then boundary waits (fixed 15, random mask 0).
    fork
      begin do_txn(0, 1'b1, 32'h0000_0400, 32'h0, 4'hF, 4'd3, 1'b0, -1); release_ch(0); end
      begin do_txn(1, 1'b0, 32'h0000_0800, 32'hCAFE_F00D, 4'b1100, 4'd1, 1'b0, -1); release_ch(1); end
    join
    fork
      begin do_txn(0, 1'b1, 32'h0000_1234, 32'h0, 4'hF, 4'hF, 1'b0, -1); release_ch(0); end
      begin do_txn(1, 1'b1, 32'h0000_5678, 32'h0, 4'hF, 4'h0, 1'b1, -1); release_ch(1); end
    join

    // Random back-to-back reads, twice from reset; stall sequences must repeat.
    do_reset();
    recording = 1'b1;
    fork
      run_reads(0, 100);
      run_reads(1, 100);
    join
    recording = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      check("rand_count_a", c, 64'(txn_count[c*CW +: CW]), 64'(100));
      rec_a[c] = rec_q[c];
      rec_q[c].delete();
    end
    do_reset();
    recording = 1'b1;
    fork
      run_reads(0, 100);
      run_reads(1, 100);
    join
    recording = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      check("rand_count_b", c, 64'(txn_count[c*CW +: CW]), 64'(100));
      mism = (rec_q[c].size() == rec_a[c].size() && rec_q[c].size() == 100) ? 0 : 1;
      for (int t = 0; t < rec_q[c].size() && t < rec_a[c].size(); t++)
        if (rec_q[c][t] != rec_a[c][t]) mism++;
      check("stall_repeat", c, 64'(mism), 64'(0));
    end

    // Mixed random traffic with gaps.
    fork
      run_mixed(0, 40);
      run_mixed(1, 40);
    join
    repeat (2) @(negedge clk);
    for (int c = 0; c < NCH; c++)
      check("mixed_count", c, 64'(txn_count[c*CW +: CW]), 64'(exp_cnt[c]));

    // Reset asserted during WAIT (after setting ch1 error flag).
    do_txn(1, 1'b1, 32'h0000_0040, 32'h0, 4'hF, 4'd4, 1'b0, 3);
    do_txn(0, 1'b1, 32'h1234_5670, 32'h0, 4'hF, 4'd8, 1'b0, 0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_stall", 0, 64'(m_stall[0]), 64'(1));
    check("async_rst_s_read", 0, 64'({s_read, s_write}), 64'(0));
    check("async_rst_s_address", 0, 64'(s_address), 64'(0));
    check("async_rst_m_rddata", 0, 64'(m_rddata), 64'(0));
    check("async_rst_count", 0, 64'(txn_count), 64'(0));
    check("async_rst_err", 0, 64'(err_premature), 64'(0));
    m_read = '0;
    for (int c = 0; c < NCH; c++) begin
      comp_q[c].delete();
      slv_q[c].delete();
      exp_cnt[c] = 0;
      last_rd[c] = '0;
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_quiet", 0, 64'({s_read, s_write}), 64'(0));
    end
    check("post_rst_err", 0, 64'(err_premature), 64'(0));

    for (int c = 0; c < NCH; c++) begin
      check("comp_q_empty", c, 64'(comp_q[c].size()), 64'(0));
      check("slv_q_empty", c, 64'(slv_q[c].size()), 64'(0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_wait_injector.md
# bus_wait_injector

Synthesisable, parametrised wait-state injector for the CPU's ibus/dbus simple-bus protocol (read/write/address/wrdata/byteenable in, rddata/stall out). It sits between NUM_CH bus masters and zero-latency slaves (e.g. the program ROM). On each channel it registers the request, performs exactly one slave access, and holds stall for a fixed or pseudo-random number of extra cycles. It flags protocol violations, where the master drops or alters a request before completion, and counts completed transactions.

## Interface
- NUM_CH, 2: number of independent master/slave channel pairs
- ADDR_WIDTH, 32: address width
- DATA_WIDTH, 32: data width; byteenable width BE_W = DATA_WIDTH/8
- WAIT_WIDTH, 4: wait-count width, 1..8
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero
- CNT_WIDTH, 16: transaction counter width

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_wait  in  NUM_CH*WAIT_WIDTH  per-channel wait count, or random mask
- cfg_random  in  NUM_CH  1 = random wait, 0 = fixed wait
- m_read, m_write  in  NUM_CH  master request strobes
- m_address  in  NUM_CH*ADDR_WIDTH  master address
- m_wrdata  in  NUM_CH*DATA_WIDTH  master write data
- m_byteenable  in  NUM_CH*BE_W  master byte enables
- m_rddata  out  NUM_CH*DATA_WIDTH  registered read data
- m_stall  out  NUM_CH  stall to master
- s_read, s_write  out  NUM_CH  slave strobes, one-cycle pulse
- s_address, s_wrdata, s_byteenable  out  per-channel widths  captured request
- s_rddata  in  NUM_CH*DATA_WIDTH  slave read data, valid in the same cycle as the strobe
- err_premature  out  NUM_CH  sticky protocol-violation flag
- txn_count  out  NUM_CH*CNT_WIDTH  completed transactions, wraps

## Operation
- Each channel runs an independent FSM with states IDLE, ACCESS, WAIT and DONE. The FSMs share one LFSR.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle.
  - Channel i takes its random value from lfsr[(i*WAIT_WIDTH)%16 +: WAIT_WIDTH].
- Wait value W: if cfg_random[i]=1, W = random value AND cfg_wait[i]; otherwise W = cfg_wait[i]. W is sampled on leaving IDLE.
- IDLE
  - m_stall = m_read|m_write (combinational).
  - On a request: capture address, wrdata, byteenable and direction (read has priority if both strobes are set); load the counter with W; go to ACCESS.
- ACCESS
  - s_read or s_write = 1 for exactly this cycle, with s_* driven from the captured registers.
  - On a read, s_rddata is latched into the data register.
  - Next state: WAIT if counter != 0, else DONE.
- WAIT: counter decrements each cycle; on the cycle it reaches 0, go to DONE.
- DONE
  - m_stall = 0 and m_rddata = data register; the master completes in this cycle.
  - txn_count increments, wrapping at 2^CNT_WIDTH.
  - Next state is IDLE.
- Violation check, in ACCESS, WAIT and DONE: if the captured-direction strobe is low, or m_address differs from the captured address:
  - set err_premature[i] (sticky until rst);
  - go straight to IDLE with no count increment;
  - a write already issued in ACCESS is not undone.
- m_stall is 1 in ACCESS and WAIT.
- m_rddata holds its value until the next read's ACCESS. A write leaves it unchanged.
- Channels never interact. Simultaneous requests on all channels proceed in parallel.

## Timing
- Reset values:
  - FSMs in IDLE; s_read, s_write = 0;
  - s_address, s_wrdata, s_byteenable, m_rddata = 0;
  - err_premature = 0; txn_count = 0; LFSR = LFSR_SEED.
  - m_stall follows the IDLE equation, so it is 1 whenever a request is present during reset.
- Rst asserted mid-transaction: immediate return to IDLE; any pending s_* pulse is cancelled asynchronously.
- Stall latency: request first seen in cycle 0, ACCESS in cycle 1, DONE in cycle 2+W. m_stall is high for cycles 0..1+W, so a transaction spans 3+W cycles.
- Back-to-back: a new request in the cycle after DONE is taken from IDLE. There are no idle gaps beyond the IDLE cycle.
- W = 2^WAIT_WIDTH-1 (15): 17 stall cycles, with no counter overflow.
- Random mode with mask 0 behaves identically to fixed W = 0.

## Test plan
- Fixed mode, ch0 cfg_wait=4, read at 0x80000010 (slave returns 0xDEADBEEF) -> s_read pulse in cycle 1; m_stall high for 6 cycles; m_rddata=0xDEADBEEF in cycle 6; txn_count[0]=1.
- Ch1 write, cfg_wait=0, data 0x12345678, BE=4'b0011 -> single s_write pulse with matching wrdata/BE; m_stall high 2 cycles; m_rddata unchanged.
- Ch0 read, cfg_wait=4, m_read dropped in the second WAIT cycle -> err_premature[0]=1 and stays set; FSM in IDLE; txn_count unchanged; the next read completes normally.
- Random mode, cfg_wait=4'hF, 100 back-to-back reads on both channels -> every stall length is in 2..17; exactly one s_read per transaction; both counts = 100; the stall sequence is repeatable after rst.
- Rst pulsed during WAIT with cfg_wait=8 -> outputs return to their reset values asynchronously; no s_* pulse follows; err_premature=0.
- Simultaneous ch0 read/ch1 write with cfg_wait 3 and 1 -> ch1 completes in cycle 3, ch0 in cycle 5; both results are correct.
